// File: rtl/period_moving_average_if.sv
// Sample/average bus between the period measure block, the moving averager and its consumer.
// The master drives period samples in and receives averaged results.
interface period_moving_average_if #(
    parameter int PERIOD_BITS = 16,
    parameter int AVG_BITS    = 4
);
    logic                          in_change_flag;
    logic [PERIOD_BITS-1:0]        in_period;
    logic                          out_change_flag;
    logic [PERIOD_BITS+AVG_BITS-1:0] out_sum;
    logic                          out_valid;
    logic                          no_signal;

    modport master (
        output in_change_flag,
        output in_period,
        input  out_change_flag,
        input  out_sum,
        input  out_valid,
        input  no_signal
    );

    modport slave (
        input  in_change_flag,
        input  in_period,
        output out_change_flag,
        output out_sum,
        output out_valid,
        output no_signal
    );
endinterface

// File: rtl/period_moving_average.sv
// Running sum of the last 2^AVG_BITS period samples; the sum is the average period with
// AVG_BITS fractional bits. History is discarded and NO_SIGNAL raised when samples stop.
module period_moving_average #(
    parameter int PERIOD_BITS  = 16,
    parameter int AVG_BITS     = 4,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    period_moving_average_if.slave io_bus
);
    localparam int N        = 1 << AVG_BITS;
    localparam int SUM_BITS = PERIOD_BITS + AVG_BITS;
    localparam logic [AVG_BITS:0]       FILL_FULL = {1'b1, {AVG_BITS{1'b0}}};
    localparam logic [TIMEOUT_BITS-1:0] IDLE_MAX  = '1;
    localparam logic [TIMEOUT_BITS-1:0] IDLE_LAST = IDLE_MAX - 1'b1;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        RUN
    } state_t;

    state_t                  r_state;
    logic [PERIOD_BITS-1:0]  r_buf [N];
    logic [AVG_BITS-1:0]     r_wr_ptr;
    logic [AVG_BITS:0]       r_fill;
    logic [SUM_BITS-1:0]     r_sum;
    logic [TIMEOUT_BITS-1:0] r_idle;
    logic [SUM_BITS-1:0]     r_out_sum;
    logic                    r_out_valid;
    logic                    r_out_change;
    logic                    r_no_signal;

    state_t                  w_next_state;
    logic [AVG_BITS-1:0]     w_next_ptr;
    logic [AVG_BITS:0]       w_next_fill;
    logic [SUM_BITS-1:0]     w_next_sum;
    logic [TIMEOUT_BITS-1:0] w_next_idle;
    logic [SUM_BITS-1:0]     w_next_out_sum;
    logic                    w_next_out_valid;
    logic                    w_next_out_change;
    logic                    w_next_no_signal;
    logic                    w_write;
    logic [PERIOD_BITS-1:0]  w_oldest;
    logic [SUM_BITS-1:0]     w_sum_upd;
    logic [AVG_BITS:0]       w_fill_inc;

    // Once the window is full the slot about to be overwritten holds the oldest sample.
    assign w_oldest   = (r_state == RUN) ? r_buf[r_wr_ptr] : '0;
    assign w_sum_upd  = r_sum + SUM_BITS'(io_bus.in_period) - SUM_BITS'(w_oldest);
    assign w_fill_inc = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;

    always_comb begin
        w_next_state      = r_state;
        w_next_ptr        = r_wr_ptr;
        w_next_fill       = r_fill;
        w_next_sum        = r_sum;
        w_next_idle       = r_idle;
        w_next_out_sum    = r_out_sum;
        w_next_out_valid  = r_out_valid;
        w_next_out_change = 1'b0;
        w_next_no_signal  = r_no_signal;
        w_write           = 1'b0;
        if (io_bus.in_change_flag) begin
            w_write           = 1'b1;
            w_next_ptr        = r_wr_ptr + 1'b1;
            w_next_fill       = w_fill_inc;
            w_next_sum        = w_sum_upd;
            w_next_idle       = '0;
            w_next_no_signal  = 1'b0;
            w_next_out_sum    = w_sum_upd;
            w_next_out_valid  = (w_fill_inc == FILL_FULL);
            w_next_out_change = (w_fill_inc == FILL_FULL);
            w_next_state      = (w_fill_inc == FILL_FULL) ? RUN : FILLING;
        end else if (r_idle != IDLE_MAX) begin
            w_next_idle = r_idle + 1'b1;
            // The idle cycle that brings the counter to its maximum is the timeout; it then sticks.
            if (r_idle == IDLE_LAST) begin
                w_next_state     = EMPTY;
                w_next_ptr       = '0;
                w_next_fill      = '0;
                w_next_sum       = '0;
                w_next_out_sum   = '0;
                w_next_out_valid = 1'b0;
                w_next_no_signal = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= EMPTY;
            r_wr_ptr     <= '0;
            r_fill       <= '0;
            r_sum        <= '0;
            r_idle       <= '0;
            r_out_sum    <= '0;
            r_out_valid  <= 1'b0;
            r_out_change <= 1'b0;
            r_no_signal  <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_wr_ptr     <= w_next_ptr;
            r_fill       <= w_next_fill;
            r_sum        <= w_next_sum;
            r_idle       <= w_next_idle;
            r_out_sum    <= w_next_out_sum;
            r_out_valid  <= w_next_out_valid;
            r_out_change <= w_next_out_change;
            r_no_signal  <= w_next_no_signal;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && w_write) begin
            r_buf[r_wr_ptr] <= io_bus.in_period;
        end
    end

    assign io_bus.out_change_flag = r_out_change;
    assign io_bus.out_sum         = r_out_sum;
    assign io_bus.out_valid       = r_out_valid;
    assign io_bus.no_signal       = r_no_signal;
endmodule
